regfile_writeback: RTL
======================

// Module: regfile_writeback
// PURPOSE
//   Write-side initiator for the 32x32 register bank: collects results from the ALU and load
//   paths, buffers them in order and drives the bank write port (enc/addrc/datac), one write
//   per clock. Sits between execute/memory stages and the register bank; also forwards
//   pending (not-yet-written) values to the operand-read side to hide write latency.
// PARAMETERS
//   DEPTH   4   pending-write FIFO entries (power of two, 2..16)
//   AW      5   register address width
//   DW      32  register data width
// PORTS
//   clock      in   1    rising-edge clock
//   reset      in   1    asynchronous, active-low reset
//   alu_valid  in   1    ALU result offered
//   alu_addr   in   AW   ALU destination register
//   alu_data   in   DW   ALU result
//   alu_ready  out  1    ALU result accepted this cycle when alu_valid&alu_ready
//   mem_valid  in   1    load result offered
//   mem_addr   in   AW   load destination register
//   mem_data   in   DW   load data
//   mem_ready  out  1    load result accepted this cycle when mem_valid&mem_ready
//   stall      in   1    1 = hold FIFO head, no bank write issued
//   flush      in   1    1 = discard all pending writes
//   fwd_addr   in   AW   register being read by operand stage
//   fwd_hit    out  1    a pending write to fwd_addr exists (combinational)
//   fwd_data   out  DW   data of youngest pending write to fwd_addr (0 when no hit)
//   enc        out  1    bank write enable (registered)
//   addrc      out  AW   bank write address (registered; zero-extended to bank width at top)
//   datac      out  DW   bank write data (registered)
//   count      out  log2(DEPTH)+1  entries pending in FIFO
// BEHAVIOUR
//   - Reset (reset=0, any time, async): FIFO empty, count=0, enc=0, addrc=0, datac=0; in-flight
//     writes are lost. Outputs return to operation on first rising edge after reset=1.
//   - Acceptance: at most one push per edge. mem has priority:
//       mem_ready = (count<DEPTH) & !flush;  alu_ready = (count<DEPTH) & !flush & !mem_valid.
//     Ready does not depend on a same-cycle pop (no full-bypass).
//   - Writes to register 0 are accepted (handshake completes) but never enqueued nor forwarded.
//   - Drain: when count>0 & !stall & !flush, head pops at the edge and enc<=1, addrc<=head addr,
//     datac<=head data; otherwise enc<=0 (addrc/datac hold last value). Bank commits at the
//     following edge. Push at edge N -> earliest enc=1 after edge N+1 -> bank updated at N+2.
//   - Simultaneous push and pop: both occur, count unchanged, order preserved (FIFO strictly
//     in acceptance order; no reordering or write-combining).
//   - Pointers wrap modulo DEPTH; count distinguishes full (DEPTH) from empty (0).
//   - flush: at the edge, FIFO cleared, count<=0, enc<=0; flush overrides push and pop. A write
//     already on enc/addrc/datac when flush rises still commits (it left the FIFO).
//   - Forwarding: search FIFO entries plus the registered output slot (when enc=1), youngest
//     first; fwd_hit=1 and fwd_data=matching data on match; fwd_addr=0 -> fwd_hit=0.
//   - stall high with full FIFO: readies low, nothing lost; contents held indefinitely.
// TESTING
//   1 Reset mid-burst: 3 pushes then reset=0 between edges -> enc=0,count=0 immediately; no writes.
//   2 Single ALU push r5=0xDEADBEEF at edge N -> enc=1,addrc=5,datac=0xDEADBEEF after N+1 only.
//   3 Both valid same cycle (mem r3=0x11, alu r4=0x22) -> mem accepted, alu_ready=0; alu next
//     cycle; bank sees r3 then r4 on consecutive enc pulses.
//   4 stall=1, push 4 entries -> count=4, readies 0, fifth held; stall=0 -> 4 enc pulses in order,
//     then push/pop same cycle keeps count steady; wrap after 6+ total pushes preserves order.
//   5 Push r7=1 then r7=2, stall=1, fwd_addr=7 -> fwd_hit=1,fwd_data=2; push r0=9 -> no enc, no hit.
//   6 flush with 3 pending and one on enc -> that one commits, count=0, no further enc.

Source files
------------

// File: rtl/regfile_writeback.sv
// Write-back buffer for the 32x32 register bank: in-order pending-write FIFO feeding the bank
// write port one entry per clock, with youngest-first forwarding of not-yet-written values.
module regfile_writeback #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 32,
    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          alu_valid,
    input  logic [AW-1:0] alu_addr,
    input  logic [DW-1:0] alu_data,
    output logic          alu_ready,
    input  logic          mem_valid,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_data,
    output logic          mem_ready,
    input  logic          stall,
    input  logic          flush,
    input  logic [AW-1:0] fwd_addr,
    output logic          fwd_hit,
    output logic [DW-1:0] fwd_data,
    output logic          enc,
    output logic [AW-1:0] addrc,
    output logic [DW-1:0] datac,
    output logic [CW-1:0] count
);

    logic [AW-1:0] r_fifo_addr [DEPTH];
    logic [DW-1:0] r_fifo_data [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          r_enc;
    logic [AW-1:0] r_addrc;
    logic [DW-1:0] r_datac;

    logic          w_not_full;
    logic          w_mem_acc;
    logic          w_alu_acc;
    logic [AW-1:0] w_in_addr;
    logic [DW-1:0] w_in_data;
    logic          w_push;
    logic          w_pop;
    logic          w_fwd_hit;
    logic [DW-1:0] w_fwd_data;

    // Readiness looks only at the current occupancy; a same-cycle pop does not free a slot.
    assign w_not_full = (r_count < CW'(DEPTH));
    assign mem_ready  = w_not_full & ~flush;
    assign alu_ready  = w_not_full & ~flush & ~mem_valid;

    assign w_mem_acc = mem_valid & mem_ready;
    assign w_alu_acc = alu_valid & alu_ready;
    assign w_in_addr = w_mem_acc ? mem_addr : alu_addr;
    assign w_in_data = w_mem_acc ? mem_data : alu_data;

    // Register 0 is hard-wired: the handshake completes but nothing is stored.
    assign w_push = (w_mem_acc | w_alu_acc) & (w_in_addr != '0);
    assign w_pop  = (r_count != '0) & ~stall & ~flush;

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= w_in_addr;
            r_fifo_data[r_wr_ptr] <= w_in_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_enc    <= 1'b0;
            r_addrc  <= '0;
            r_datac  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_enc    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_enc    <= 1'b1;
                r_addrc  <= r_fifo_addr[r_rd_ptr];
                r_datac  <= r_fifo_data[r_rd_ptr];
            end else begin
                r_enc    <= 1'b0;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Scan oldest to youngest so the last match (youngest) wins; the output slot is older
    // than every FIFO entry.
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        if (r_enc && (r_addrc == fwd_addr)) begin
            w_fwd_hit  = 1'b1;
            w_fwd_data = r_datac;
        end
        for (int k = 0; k < DEPTH; k++) begin
            if ((CW'(k) < r_count) && (r_fifo_addr[r_rd_ptr + PW'(k)] == fwd_addr)) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = r_fifo_data[r_rd_ptr + PW'(k)];
            end
        end
        if (fwd_addr == '0) begin
            w_fwd_hit  = 1'b0;
            w_fwd_data = '0;
        end
    end

    assign fwd_hit  = w_fwd_hit;
    assign fwd_data = w_fwd_data;
    assign enc      = r_enc;
    assign addrc    = r_addrc;
    assign datac    = r_datac;
    assign count    = r_count;

endmodule
